// File: rtl/button_pkg.sv
// Shared definitions for the panel push-button front end:
// button indices, debounce FSM states and default timing constants.
package button_pkg;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_M = 4;

    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;
    localparam int DEF_REPEAT_MASK     = (1 << BTN_U) | (1 << BTN_D);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Ports: clk_osc, resetn (async, active-low), push (raw level);
//   press/released (1-cycle pulses), held (debounced level), press_next
//   (next-cycle value of press, used for the top-level any_press flop).
// Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BUTTON_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN     = 1'b0
`endif
) (
    input  logic clk_osc,
    input  logic resetn,
    input  logic push,
    output logic press,
    output logic released,
    output logic held,
    output logic press_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    btn_state_t    state;
    btn_state_t    state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          deb_press;
    logic          rel_d;
    logic          held_d;
    logic          rpt_fire;

    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= push;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            press    <= 1'b0;
            released <= 1'b0;
            held     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            press    <= press_next;
            released <= rel_d;
            held     <= held_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        deb_press = 1'b0;
        rel_d     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s2) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s2) begin
                    state_d = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_d   = ST_HELD;
                    deb_press = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!s2) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s2) begin
                    state_d = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        held_d     = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
        press_next = deb_press | rpt_fire;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    generate
        if (REPEAT_EN) begin : g_rpt
            localparam int RMAX =
                (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RCW = $clog2(RMAX + 1);

            logic [RCW-1:0] rcnt;
            logic           rphase;
            logic           tick;
            logic           hit;

            // Counts only while stably held; RELEASE_WAIT freezes it so a
            // bounce pauses repeating without restarting the initial delay.
            assign tick = (state == ST_HELD) && s2;
            assign hit  = tick && (rcnt == (rphase ?
                          RCW'(REPEAT_PERIOD - 1) : RCW'(REPEAT_DELAY - 1)));
            assign rpt_fire = hit;

            always_ff @(posedge clk_osc or negedge resetn) begin
                if (!resetn) begin
                    rcnt   <= '0;
                    rphase <= 1'b0;
                end else if (state_d == ST_IDLE) begin
                    rcnt   <= '0;
                    rphase <= 1'b0;
                end else if (hit) begin
                    rcnt   <= '0;
                    rphase <= 1'b1;
                end else if (tick) begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
        end
    endgenerate
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Panel push-button front end: per-button synchronise, debounce, pulse.
// Ports: clk_osc, resetn (async, active-low), push[N_BTN] (raw, order
//   u,d,l,r,m); press/released (1-cycle pulses), held (debounced level),
//   any_press (registered OR of press). Macro: BUTTON_AUTO_REPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int               N_BTN           = DEF_N_BTN,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(DEF_REPEAT_MASK)
) (
    input  logic             clk_osc,
    input  logic             resetn,
    input  logic [N_BTN-1:0] push,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] held,
    output logic             any_press
);

    logic [N_BTN-1:0] press_next;

    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
        begin : g_bad_cfg
            $error("button_conditioner: timing parameters must be >= 1");
        end

        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
                ,
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[gi])
`endif
            ) u_deb (
                .clk_osc    (clk_osc),
                .resetn     (resetn),
                .push       (push[gi]),
                .press      (press[gi]),
                .released   (released[gi]),
                .held       (held[gi]),
                .press_next (press_next[gi])
            );
        end
    endgenerate

    // Registered from the same next-state terms as press so it lines up.
    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised + directed bench for button_conditioner against a
// run-length reference model of the debounce/repeat rules.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam logic [N-1:0] MASK = 5'b00011;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic         clk_osc = 1'b0;
    logic         resetn  = 1'b0;
    logic [N-1:0] push    = '0;
    logic [N-1:0] press;
    logic [N-1:0] released;
    logic [N-1:0] held;
    logic         any_press;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    always #5 clk_osc = ~clk_osc;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk_osc   (clk_osc),
        .resetn    (resetn),
        .push      (push),
        .press     (press),
        .released  (released),
        .held      (held),
        .any_press (any_press)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
                     tag, obs, exp, edge_n, $time);
        end
    endtask

    // Reference model: a level is accepted after DC+1 consecutive
    // synchronised samples that differ from the accepted level.
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    logic [N-1:0] seen;
    bit           acc   [N];
    int           run   [N];
    int           ticks [N];
    logic [N-1:0] e_press = '0;
    logic [N-1:0] e_rel   = '0;
    logic [N-1:0] e_held  = '0;
    logic         e_any   = 1'b0;

    function automatic bit rpt_due(input int t);
        return (t == RD) || (t > RD && ((t - RD) % RP) == 0);
    endfunction

    always @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            edge_n = 0;
            m_s1 = '0; m_s2 = '0;
            e_press = '0; e_rel = '0; e_held = '0; e_any = 1'b0;
            for (int i = 0; i < N; i++) begin
                acc[i] = 1'b0; run[i] = 0; ticks[i] = 0;
            end
        end else begin
            edge_n++;
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = push;
            e_press = '0;
            e_rel   = '0;
            for (int i = 0; i < N; i++) begin
                if (RPT && MASK[i] && acc[i] && run[i] == 0 && seen[i]) begin
                    ticks[i]++;
                    if (rpt_due(ticks[i])) e_press[i] = 1'b1;
                end
                if (seen[i] != acc[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == DC + 1) begin
                    acc[i]   = !acc[i];
                    run[i]   = 0;
                    ticks[i] = 0;
                    if (acc[i]) e_press[i] = 1'b1;
                    else e_rel[i] = 1'b1;
                end
                e_held[i] = acc[i];
            end
            e_any = |e_press;
        end
    end

    always @(negedge clk_osc) begin
        check("m_press", 32'(press), 32'(e_press));
        check("m_release", 32'(released), 32'(e_rel));
        check("m_held", 32'(held), 32'(e_held));
        check("m_any", 32'(any_press), 32'(e_any));
    end

    task automatic at_edge(input int e);
        do @(negedge clk_osc); while (edge_n < e);
    endtask

    task automatic do_reset(input int cycles);
        #2 resetn = 1'b0;
        #1;
        check("rst_press", 32'(press), 0);
        check("rst_release", 32'(released), 0);
        check("rst_held", 32'(held), 0);
        check("rst_any", 32'(any_press), 0);
        repeat (cycles) @(negedge clk_osc);
        #2 resetn = 1'b1;
    endtask

    int c;
    int cnt_u;
    int cnt_l;

    initial begin
        repeat (3) @(negedge clk_osc);
        check("reset_state", {press, released, held, 3'b0, any_press}, 0);
        #2 resetn = 1'b1;

        // Clean press: first sampled at edge 10 -> press after edge 16.
        at_edge(9);  push[0] = 1'b1;
        at_edge(15); check("clean_early", 32'(press[0]), 0);
        at_edge(16); check("clean_press", 32'(press[0]), 1);
        check("clean_held", 32'(held[0]), 1);
        check("clean_any", 32'(any_press), 1);
        at_edge(17); check("clean_width", 32'(press[0]), 0);

        // Bounce on button 1 at 2-cycle intervals.
        at_edge(19); push[1] = 1'b1;
        at_edge(21); push[1] = 1'b0;
        at_edge(23); push[1] = 1'b1;
        at_edge(25); push[1] = 1'b0;
        at_edge(35); check("bounce_held", 32'(held[1]), 0);

        // Release: first sampled 0 at edge 40 -> release after edge 46.
        at_edge(39); push[0] = 1'b0;
        at_edge(45); check("rel_early", 32'(released[0]), 0);
        check("rel_held_before", 32'(held[0]), 1);
        at_edge(46); check("rel_pulse", 32'(released[0]), 1);
        check("rel_held_after", 32'(held[0]), 0);

        // Simultaneous press on buttons 3 and 4.
        at_edge(49); push[4:3] = 2'b11;
        at_edge(56); check("simul_press", 32'(press[4:3]), 32'h3);
        at_edge(60); push[4:3] = 2'b00;

        // Reset while button 2 is held; it is kept pressed throughout.
        at_edge(69); push[2] = 1'b1;
        at_edge(76); check("pre_rst_press", 32'(press[2]), 1);
        at_edge(80); do_reset(2);
        at_edge(6);  check("post_rst_early", 32'(press[2]), 0);
        check("post_rst_norel", 32'(released), 0);
        at_edge(7);  check("post_rst_press", 32'(press[2]), 1);
        at_edge(8);  push[2] = 1'b0;

        // Auto-repeat: hold button 0 and button 2 together.
        at_edge(19); push[0] = 1'b1; push[2] = 1'b1;
        c = 26;
        at_edge(c); check("rpt_initial", 32'(press[0]), 1);
        cnt_u = 0; cnt_l = 0;
        for (int e = c + 1; e <= c + 45; e++) begin
            at_edge(e);
            if (e == c + 36) begin
                push[0] = 1'b0; push[2] = 1'b0;
            end
            if (press[0]) cnt_u++;
            if (press[2]) cnt_l++;
            if (e == c + 20) check("rpt_first", 32'(press[0]), 32'(RPT));
        end
        check("rpt_count_u", cnt_u, RPT ? 4 : 0);
        check("rpt_count_l", cnt_l, 0);

        // Random traffic with occasional resets, checked by the model.
        for (int k = 0; k < 900; k++) begin
            @(negedge clk_osc);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) push[i] = ~push[i];
            if ($urandom_range(0, 199) == 0)
                do_reset(int'($urandom_range(1, 3)));
        end

        push = '0;
        repeat (20) @(negedge clk_osc);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
